// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths, port indices and FSM encoding for mem_arbiter
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two requester ports plus the shared data-memory port
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                  m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [MEM_ADDR_W-1:0] m0_addr;
  logic [MEM_DATA_W-1:0] m0_wdata, m0_rdata;
  logic [MEM_BE_W-1:0]   m0_be;

  logic                  m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [MEM_ADDR_W-1:0] m1_addr;
  logic [MEM_DATA_W-1:0] m1_wdata, m1_rdata;
  logic [MEM_BE_W-1:0]   m1_be;

  logic                  mem_req, mem_we, mem_ready;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_DATA_W-1:0] mem_wdata, mem_rdata;
  logic [MEM_BE_W-1:0]   mem_be;

  // arbiter view
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  // requester/memory environment view
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - 2-way grant selector
// ARB_ROUND_ROBIN_EN: alternate on contention; otherwise port 0 has fixed priority.
module arb_pick
  import mem_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       last,
`endif
  input  logic [1:0] req,
  output logic       valid,
  output logic       idx
);

  always_comb begin
    valid = |req;
    idx   = PORT0;
    if (req == 2'b10) begin
      idx = PORT1;
    end else if (req == 2'b11) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = ~last;
`else
      idx = PORT0;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two requesters sharing one data-memory port with timeout abort
// ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t       state;
  logic             owner;
  logic [CNT_W-1:0] cnt;
  logic             pick_valid, pick_idx;
  logic             timeout;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  arb_pick u_pick (
    .last  (last_gnt),
    .req   ({bus.m1_req, bus.m0_req}),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
`else
  arb_pick u_pick (
    .req   ({bus.m1_req, bus.m0_req}),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
`endif

  assign timeout = !bus.mem_ready && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      owner         <= PORT0;
      cnt           <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt      <= PORT1;
`endif
      bus.m0_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m0_err    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m1_rdata  <= '0;
      bus.m1_err    <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
    end else begin
      // pulses and response fields live for exactly one cycle
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
      bus.m0_err    <= 1'b0;
      bus.m1_err    <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner         <= pick_idx;
            cnt           <= '0;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= pick_idx ? bus.m1_we    : bus.m0_we;
            bus.mem_addr  <= pick_idx ? bus.m1_addr  : bus.m0_addr;
            bus.mem_wdata <= pick_idx ? bus.m1_wdata : bus.m0_wdata;
            bus.mem_be    <= pick_idx ? bus.m1_be    : bus.m0_be;
            bus.m0_gnt    <= (pick_idx == PORT0);
            bus.m1_gnt    <= (pick_idx == PORT1);
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt      <= pick_idx;
`endif
            state         <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (bus.mem_ready || timeout) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
            cnt           <= '0;
            // writes and timeouts return zero data
            if (owner == PORT0) begin
              bus.m0_rvalid <= 1'b1;
              bus.m0_err    <= timeout;
              bus.m0_rdata  <= (bus.mem_ready && !bus.mem_we) ? bus.mem_rdata : '0;
            end else begin
              bus.m1_rvalid <= 1'b1;
              bus.m1_err    <= timeout;
              bus.m1_rdata  <= (bus.mem_ready && !bus.mem_we) ? bus.mem_rdata : '0;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles;
    logic saw_drop;

    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;

    // reset state
    step(); step();
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_m0_gnt", bus.m0_gnt, 0);
    chk("rst_m1_rvalid", bus.m1_rvalid, 0);
    reset = 1;
    step();

    // m0 read, memory ready on first BUSY cycle
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h100; bus.m0_be = 4'hF;
    step();
    chk("rd_m0_gnt", bus.m0_gnt, 1);
    chk("rd_m1_gnt", bus.m1_gnt, 0);
    chk("rd_mem_req", bus.mem_req, 1);
    chk("rd_mem_addr", bus.mem_addr, 32'h100);
    chk("rd_mem_we", bus.mem_we, 0);
    bus.m0_req = 0;
    bus.mem_ready = 1; bus.mem_rdata = 32'hCAFEBABE;
    step();
    chk("rd_m0_rvalid", bus.m0_rvalid, 1);
    chk("rd_m0_rdata", bus.m0_rdata, 32'hCAFEBABE);
    chk("rd_m0_err", bus.m0_err, 0);
    chk("rd_mem_req_off", bus.mem_req, 0);
    bus.mem_ready = 0;
    step();
    chk("rd_m0_rvalid_off", bus.m0_rvalid, 0);

    // m1 write with one wait cycle
    bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h1000_0000;
    bus.m1_wdata = 32'h1234_5678; bus.m1_be = 4'b1111;
    step();
    chk("wr_m1_gnt", bus.m1_gnt, 1);
    chk("wr_m0_gnt", bus.m0_gnt, 0);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 32'h1000_0000);
    chk("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    chk("wr_mem_be", bus.mem_be, 4'hF);
    bus.m1_req = 0;
    step();
    chk("wr_mem_req_wait", bus.mem_req, 1);
    chk("wr_mem_addr_wait", bus.mem_addr, 32'h1000_0000);
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    step();
    chk("wr_m1_rvalid", bus.m1_rvalid, 1);
    chk("wr_m1_rdata", bus.m1_rdata, 0);
    chk("wr_m0_rvalid", bus.m0_rvalid, 0);
    bus.mem_ready = 0; bus.m1_we = 0;
    step();

    // simultaneous requests, twice
    bus.m0_req = 1; bus.m0_addr = 32'h400;
    bus.m1_req = 1; bus.m1_addr = 32'h500;
    step();
    chk("arb1_m0_gnt", bus.m0_gnt, 1);
    chk("arb1_m1_gnt", bus.m1_gnt, 0);
    chk("arb1_mem_addr", bus.mem_addr, 32'h400);
    bus.m0_req = 0;
    bus.mem_ready = 1; bus.mem_rdata = 32'h1111_1111;
    step();
    chk("arb1_m0_rvalid", bus.m0_rvalid, 1);
    chk("arb1_m1_rvalid", bus.m1_rvalid, 0);
    chk("arb1_m0_rdata", bus.m0_rdata, 32'h1111_1111);
    bus.mem_ready = 0; bus.m0_req = 1;
    step();
    chk("arb_idle_m1_gnt", bus.m1_gnt, 0);
    step();
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb2_m0_gnt", bus.m0_gnt, 0);
    chk("arb2_m1_gnt", bus.m1_gnt, 1);
    chk("arb2_mem_addr", bus.mem_addr, 32'h500);
    bus.m1_req = 0;
`else
    chk("arb2_m0_gnt", bus.m0_gnt, 1);
    chk("arb2_m1_gnt", bus.m1_gnt, 0);
    chk("arb2_mem_addr", bus.mem_addr, 32'h400);
    bus.m0_req = 0;
`endif
    bus.mem_ready = 1; bus.mem_rdata = 32'h2222_2222;
    step();
`ifdef ARB_ROUND_ROBIN_EN
    chk("arb2_m1_rvalid", bus.m1_rvalid, 1);
    chk("arb2_m1_rdata", bus.m1_rdata, 32'h2222_2222);
    chk("arb2_m0_rvalid", bus.m0_rvalid, 0);
`else
    chk("arb2_m0_rvalid", bus.m0_rvalid, 1);
    chk("arb2_m0_rdata", bus.m0_rdata, 32'h2222_2222);
    chk("arb2_m1_rvalid", bus.m1_rvalid, 0);
`endif
    bus.m0_req = 0; bus.m1_req = 0; bus.mem_ready = 0;
    step();

    // timeout: mem_ready never arrives
    bus.m0_req = 1; bus.m0_addr = 32'h200; bus.mem_rdata = 32'hFFFF_FFFF;
    step();
    bus.m0_req = 0;
    busy_cycles = 0;
    saw_drop = 0;
    for (int i = 0; i < 40 && !saw_drop; i++) begin
      if (bus.mem_req) begin
        busy_cycles++;
        step();
      end else begin
        saw_drop = 1;
      end
    end
    chk("to_dropped", saw_drop, 1);
    chk("to_busy_cycles", busy_cycles, 15);
    chk("to_m0_rvalid", bus.m0_rvalid, 1);
    chk("to_m0_err", bus.m0_err, 1);
    chk("to_m0_rdata", bus.m0_rdata, 0);
    step();

    // mem_ready in the last allowed BUSY cycle is a success
    bus.m0_req = 1; bus.m0_addr = 32'h204;
    step();
    bus.m0_req = 0;
    for (int i = 0; i < 14; i++) step();
    chk("edge_mem_req", bus.mem_req, 1);
    bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5_A5A5;
    step();
    chk("edge_m0_rvalid", bus.m0_rvalid, 1);
    chk("edge_m0_err", bus.m0_err, 0);
    chk("edge_m0_rdata", bus.m0_rdata, 32'hA5A5_A5A5);
    bus.mem_ready = 0;
    step();

    // mem_ready outside BUSY is ignored
    bus.mem_ready = 1;
    step();
    chk("idle_ready_m0_rvalid", bus.m0_rvalid, 0);
    chk("idle_ready_m1_rvalid", bus.m1_rvalid, 0);
    chk("idle_ready_mem_req", bus.mem_req, 0);
    bus.mem_ready = 0;
    step();

    // reset in BUSY cycle 3
    bus.m0_req = 1; bus.m0_addr = 32'h300;
    step();
    bus.m0_req = 0;
    step(); step();
    chk("rst_mid_mem_req_before", bus.mem_req, 1);
    reset = 0;
    #1;
    chk("rst_mid_mem_req_async", bus.mem_req, 0);
    step();
    reset = 1;
    step(); step();
    chk("rst_mid_no_rvalid", bus.m0_rvalid, 0);
    chk("rst_mid_no_err", bus.m0_err, 0);
    bus.m0_req = 1; bus.m0_addr = 32'h300;
    step();
    chk("post_rst_m0_gnt", bus.m0_gnt, 1);
    chk("post_rst_mem_addr", bus.mem_addr, 32'h300);
    bus.m0_req = 0;
    bus.mem_ready = 1; bus.mem_rdata = 32'h5A5A_0000;
    step();
    chk("post_rst_m0_rvalid", bus.m0_rvalid, 1);
    chk("post_rst_m0_rdata", bus.m0_rdata, 32'h5A5A_0000);
    bus.mem_ready = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15; max cycles a transaction waits for mem_ready before it is aborted.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low (0 = reset); name and polarity fixed.
REQ-004 mN_req  input  1  requester N (N=0 MEM stage, N=1 secondary/DMA) transaction request; held until mN_gnt.
REQ-005 mN_we, mN_addr, mN_wdata, mN_be  input  1/32/32/4  write enable, byte address, store data, byte enables; stable while mN_req=1.
REQ-006 mN_gnt  output  1  one-cycle pulse: request accepted and latched.
REQ-007 mN_rvalid, mN_rdata, mN_err  output  1/32/1  one-cycle completion pulse, read data, timeout flag (valid only with rvalid).
REQ-008 mem_req, mem_we, mem_addr, mem_wdata, mem_be  output  1/1/32/32/4  single shared data-memory port.
REQ-009 mem_ready, mem_rdata  input  1/32  memory completion strobe and read data.

Function
REQ-010 The block SHALL run FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-011 IDLE: if any mN_req=1, select winner, latch its we/addr/wdata/be, pulse winner mN_gnt next cycle, enter BUSY; else stay IDLE.
REQ-012 BUSY: mem_req=1 with latched fields every cycle until mem_ready=1 sampled, then capture mem_rdata and enter RESP.
REQ-013 BUSY: a cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYCLES without mem_ready, drop mem_req, set err, enter RESP.
REQ-014 mem_ready sampled in the same cycle the counter hits TIMEOUT_CYCLES SHALL count as success (no err).
REQ-015 RESP: winner mN_rvalid=1 for exactly one cycle with captured rdata (0 for writes and timeouts) and err; return to IDLE.
REQ-016 Minimum latency: req sampled at edge k -> gnt/mem_req at k+1 -> mem_ready at k+1 -> rvalid at k+2; one transaction per 3 cycles max.
REQ-017 Only the granted requester's gnt/rvalid SHALL ever pulse; the loser's outputs stay 0 and its request remains pending.
REQ-018 mem_ready while not in BUSY SHALL be ignored.
REQ-019 A requester still asserting req in the IDLE cycle after its rvalid SHALL be treated as a new transaction.
REQ-020 mN_be and mN_addr SHALL pass through unmodified (alignment is the requester's responsibility).

Reset
REQ-021 reset=0 SHALL immediately force state IDLE, counter 0, all outputs 0, last-grant pointer to port 1 (port 0 wins first).
REQ-022 Reset mid-transaction SHALL drop it silently: no rvalid, no err, mem_req deasserted asynchronously.

Configuration
REQ-023 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests grant the port not granted last; pointer updates on each gnt.
REQ-024 Macro undefined: fixed priority, port 0 always wins simultaneous requests; no pointer register.

Structure
REQ-025 FSM state encodings and port-index constants SHALL live in the shared constants include alongside existing MEM_* width codes.
REQ-026 One sub-module, arb_pick (2-way grant selector, round-robin or fixed per macro), is natural; FSM/datapath stay in mem_arbiter.

Verification
REQ-027 m0 read addr 0x100, mem_ready one cycle after mem_req, mem_rdata 0xCAFEBABE -> m0_gnt pulse, m0_rvalid=1, m0_rdata=0xCAFEBABE, m0_err=0.
REQ-028 m1 write addr 0x10000000, wdata 0x12345678, be 4'b1111 -> mem_we=1, mem_addr/mem_wdata/mem_be match while mem_req=1; m1_rvalid pulse.
REQ-029 m0 and m1 request same cycle, repeated twice -> with ARB_ROUND_ROBIN_EN grants m0 then m1; without it m0 then m0 (m1 waits).
REQ-030 mem_ready held 0, TIMEOUT_CYCLES=15 -> mem_req drops after 15 BUSY cycles, m0_rvalid=1, m0_err=1, m0_rdata=0.
REQ-031 reset=0 asserted in BUSY cycle 3 -> mem_req=0 immediately, no rvalid; after release m0 next request served normally.
